// File: rtl/adder8_pkg.sv
// adder8 shared definitions: default width and the stage-1 pipeline record.
// Optional signed-overflow output is enabled with ADDER8_OVF_EN.
package adder8_pkg;

   localparam int ADDER8_DEFAULT_WIDTH = 8;
   localparam int ADDER8_DEFAULT_H     = ADDER8_DEFAULT_WIDTH / 2;

   typedef struct packed {
      logic [ADDER8_DEFAULT_H-1:0] lo_sum;
      logic                        lo_carry;
      logic [ADDER8_DEFAULT_H-1:0] hi_a;
      logic [ADDER8_DEFAULT_H-1:0] hi_b;
      logic                        valid;
   } adder8_s1_t;

endpackage

// File: rtl/adder8_slice.sv
// adder8_slice: combinational W-bit adder with carry-in and carry-out.
// Used once per operand half of adder8.
module adder8_slice #(
   parameter int W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cout
);

   logic [W:0] full;

   assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
   assign s    = full[W-1:0];
   assign cout = full[W];

endmodule

// File: rtl/adder8.sv
// adder8: two-stage pipelined unsigned adder, low half then high half.
// Define ADDER8_OVF_EN to add the registered signed-overflow output ovf.
module adder8
   import adder8_pkg::*;
#(
   parameter int WIDTH = ADDER8_DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             out_valid,
   output logic [WIDTH-1:0] sum,
   output logic             cout
`ifdef ADDER8_OVF_EN
   ,
   output logic             ovf
`endif
);

   localparam int H = WIDTH / 2;

   if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
      $error("adder8: WIDTH must be even and >= 2");
   end

   // Same layout as adder8_s1_t, sized for this instance's WIDTH.
   typedef struct packed {
      logic [H-1:0] lo_sum;
      logic         lo_carry;
      logic [H-1:0] hi_a;
      logic [H-1:0] hi_b;
      logic         valid;
   } s1_t;

   s1_t          s1;
   logic [H-1:0] lo_sum_c;
   logic         lo_co_c;
   logic [H-1:0] hi_sum_c;
   logic         hi_co_c;

   adder8_slice #(.W(H)) u_lo (
      .a    (a[H-1:0]),
      .b    (b[H-1:0]),
      .cin  (1'b0),
      .s    (lo_sum_c),
      .cout (lo_co_c)
   );

   adder8_slice #(.W(H)) u_hi (
      .a    (s1.hi_a),
      .b    (s1.hi_b),
      .cin  (s1.lo_carry),
      .s    (hi_sum_c),
      .cout (hi_co_c)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= '0;
      end else begin
         s1.valid <= in_valid;
         if (in_valid) begin
            s1.lo_sum   <= lo_sum_c;
            s1.lo_carry <= lo_co_c;
            s1.hi_a     <= a[WIDTH-1:H];
            s1.hi_b     <= b[WIDTH-1:H];
         end
      end
   end

`ifdef ADDER8_OVF_EN
   logic ovf_c;

   // Operand MSBs live at the top of the registered high halves.
   assign ovf_c = (s1.hi_a[H-1] == s1.hi_b[H-1]) &&
                  (hi_sum_c[H-1] != s1.hi_a[H-1]);
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
`ifdef ADDER8_OVF_EN
         ovf       <= 1'b0;
`endif
      end else begin
         out_valid <= s1.valid;
         if (s1.valid) begin
            sum  <= {hi_sum_c, s1.lo_sum};
            cout <= hi_co_c;
`ifdef ADDER8_OVF_EN
            ovf  <= ovf_c;
`endif
         end
      end
   end

endmodule

// File: tb/tb_adder8.sv
// tb_adder8: randomized and directed scoreboard bench for adder8.
// Expected results come from plain integer arithmetic on the operands.
module tb_adder8;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         out_valid;
   logic [W-1:0] sum;
   logic         cout;
`ifdef ADDER8_OVF_EN
   logic         ovf;
`endif

   int checks = 0;
   int errors = 0;
   int issued = 0;
   int seen   = 0;

   logic [W:0] exp_q[$];
   logic       exp_ovf_q[$];

   adder8 #(.WIDTH(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .sum       (sum),
      .cout      (cout)
`ifdef ADDER8_OVF_EN
      ,
      .ovf       (ovf)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic ref_ovf(input int x, input int y);
      int sx, sy, r;
      sx = (x >= 128) ? x - 256 : x;
      sy = (y >= 128) ? y - 256 : y;
      r  = sx + sy;
      return (r > 127) || (r < -128);
   endfunction

   // Present one pair for one cycle (or idle when v=0).
   task automatic drive(input logic v, input int x, input int y);
      int t;
      @(posedge clk);
      #1;
      in_valid = v;
      a = W'(x);
      b = W'(y);
      if (v) begin
         t = x + y;
         exp_q.push_back((W+1)'(t));
         exp_ovf_q.push_back(ref_ovf(x, y));
         issued++;
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, $urandom_range(0, 255), $urandom_range(0, 255));
   endtask

   task automatic check_zero(input string name);
      logic z;
      z = (out_valid == 1'b0) && (sum == '0) && (cout == 1'b0);
`ifdef ADDER8_OVF_EN
      z = z && (ovf == 1'b0);
`endif
      checks++;
      if (!z) begin
         errors++;
         $display("FAIL %s: got valid=%0b sum=%02h cout=%0b, required all zero",
                  name, out_valid, sum, cout);
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(posedge clk);
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d results outstanding, required 0", exp_q.size());
         exp_q.delete();
         exp_ovf_q.delete();
      end
   endtask

   // Monitor: compares every presented result with the oldest expectation.
   always @(negedge clk) begin
      logic [W:0] e;
      logic       eo;
      if (rst_n && out_valid) begin
         seen++;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL strobe: out_valid=1 with sum=%02h, required no result", sum);
         end else begin
            e  = exp_q.pop_front();
            eo = exp_ovf_q.pop_front();
            if ({cout, sum} !== e) begin
               errors++;
               $display("FAIL result: got cout=%0b sum=%02h, required cout=%0b sum=%02h",
                        cout, sum, e[W], e[W-1:0]);
            end
`ifdef ADDER8_OVF_EN
            checks++;
            if (ovf !== eo) begin
               errors++;
               $display("FAIL ovf: got %0b, required %0b (sum=%02h)", ovf, eo, sum);
            end
`else
            if (eo === 1'bx) $display("unexpected x in ovf model");
`endif
         end
      end
   end

   logic [W-1:0] hold_sum;
   logic         hold_cout;

   initial begin
      void'($urandom(32'h1234_5678));

      // Reset held: toggling inputs must not reach the outputs.
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         in_valid = ~in_valid;
         a = W'($urandom_range(0, 255));
         b = W'($urandom_range(0, 255));
         @(negedge clk);
         check_zero("reset_held");
      end
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      rst_n = 1'b1;

      // Directed: basic, inter-half carry, wrap-around.
      drive(1'b1, 8'h24, 8'h81);
      idle(3);
      drive(1'b1, 8'h0F, 8'h01);
      drive(1'b1, 8'hFF, 8'h01);
      drive(1'b1, 8'hFF, 8'hFF);
      drive(1'b1, 8'h7F, 8'h01);
      drive(1'b1, 8'h80, 8'h80);
      drive(1'b1, 8'h40, 8'hC0);
      idle(1);
      wait_drain();

      // Back-to-back random stream.
      for (int i = 0; i < 5; i++) drive(1'b1, $urandom_range(0, 255), $urandom_range(0, 255));
      idle(1);
      wait_drain();

      // Hold: changing operands with in_valid low.
      drive(1'b1, 8'h3C, 8'hD9);
      idle(3);
      wait_drain();
      hold_sum  = sum;
      hold_cout = cout;
      for (int i = 0; i < 4; i++) begin
         drive(1'b0, 8'h55, 8'hAA);
         @(negedge clk);
         checks++;
         if (sum !== hold_sum || cout !== hold_cout || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold: got sum=%02h cout=%0b valid=%0b, required sum=%02h cout=%0b valid=0",
                     sum, cout, out_valid, hold_sum, hold_cout);
         end
      end

      // Random traffic with gaps.
      for (int i = 0; i < 200; i++)
         drive(($urandom_range(0, 3) != 0), $urandom_range(0, 255), $urandom_range(0, 255));
      idle(1);
      wait_drain();

      // Asynchronous reset with two pairs in flight.
      drive(1'b1, 8'h11, 8'h22);
      drive(1'b1, 8'hF0, 8'h33);
      @(posedge clk);
      #3;
      in_valid = 1'b0;
      rst_n = 1'b0;
      exp_q.delete();
      exp_ovf_q.delete();
      issued -= 2;
      #1;
      check_zero("async_reset");
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check_zero("reset_flush");
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check_zero("post_reset_quiet");
      end

      // Traffic resumes after reset.
      drive(1'b1, 8'hFF, 8'h01);
      drive(1'b1, 8'h9A, 8'h9A);
      idle(1);
      wait_drain();

      checks++;
      if (seen != issued) begin
         errors++;
         $display("FAIL count: got %0d results, required %0d", seen, issued);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
